prewitt_window_gen: RTL and testbench
=====================================

// Module: prewitt_window_gen
// PURPOSE
//  Streaming 3x3 window generator feeding the Prewitt kernel stages (vertical/horizontal).
//  - Accepts one raster-order 8-bit pixel per valid cycle and buffers two image lines.
//  - Emits registered p1..p9 windows: p1 p2 p3 = top row, p7 p8 p9 = bottom row.
//  - Emits only fully-interior windows (no padding); the kernel stages consume p1..p9 directly.
// PARAMETERS
//  DATA_W  8   pixel width
//  IMG_W   64  pixels per line (>=3)
//  IMG_H   64  lines per frame (>=3)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       in_pix valid this cycle; no backpressure, gaps of any length allowed
//  in_sof     in   1       qualified by in_valid: this pixel is (row 0, col 0)
//  in_pix     in   DATA_W  input pixel, raster order
//  out_valid  out  1       p1..p9 hold a new window this cycle (one-cycle pulse per window)
//  p1..p9     out  DATA_W  window pixels, registered
//  win_eol    out  1       [PREWITT_WIN_FLAGS_EN only] last window of an output row
//  win_eof    out  1       [PREWITT_WIN_FLAGS_EN only] last window of the frame
// BEHAVIOUR
//  - Reset: col=0, row=0, out_valid=0, p1..p9=0, win_eol=win_eof=0; line RAMs not cleared.
//  - Counters: col 0..IMG_W-1, row 0..IMG_H-1; advance only on in_valid.
//    col wraps to 0 and increments row; at (IMG_H-1, IMG_W-1) both wrap to 0.
//  - in_sof with in_valid: the pixel is treated as (0,0), overriding the counters.
//    Mid-frame in_sof abandons the current frame; no window is emitted until row>=2 again.
//  - Line buffers lb_old (row r-2) and lb_mid (row r-1), IMG_W deep, indexed by col.
//    Read-before-write: on accept, lb_old[col]<=lb_mid[col], lb_mid[col]<=in_pix.
//  - Window shift on accept:
//    p1<=p2, p2<=p3, p3<=lb_old[col];
//    p4<=p5, p5<=p6, p6<=lb_mid[col];
//    p7<=p8, p8<=p9, p9<=in_pix.
//  - out_valid <= in_valid && row>=2 && col>=2, evaluated on the pre-increment counters.
//  - Latency: the window whose bottom-right is pixel (r,c) is valid one cycle after (r,c) is accepted.
//  - in_valid=0: out_valid<=0; p1..p9 and counters hold.
//  - Windows never span a line wrap: the col>=2 gate discards the two stale columns.
//  - Per frame: exactly (IMG_W-2)*(IMG_H-2) out_valid pulses.
//  - Frames may be back-to-back with no gap.
//  - rst mid-frame: next cycle out_valid=0, counters at 0; the next pixel accepted is row 0.
// CONFIGURATION
//  PREWITT_WIN_FLAGS_EN defined:
//    - adds win_eol/win_eof, registered alongside out_valid;
//    - win_eol=1 when col==IMG_W-1; win_eof=1 when additionally row==IMG_H-1;
//    - both are 0 whenever out_valid=0.
//  PREWITT_WIN_FLAGS_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - prewitt_pkg: DATA_W/IMG_W/IMG_H defaults, pixel_t typedef, and
//    COL_W=$clog2(IMG_W), ROW_W=$clog2(IMG_H) helper constants.
//  - Sub-module prewitt_line_buf:
//    - one IMG_W x DATA_W line, synchronous-write / combinational-read, read-before-write;
//    - instantiated twice (lb_old, lb_mid).
//  - Top level owns the counters, the 3x3 shift register and the flag logic.
// TESTING (IMG_W=4, IMG_H=4, pixel = row*16+col, continuous in_valid)
//  1. One frame, first pixel with in_sof.
//     -> first out_valid the cycle after pixel 0x22: p1..p9 = 00 01 02 10 11 12 20 21 22.
//     -> exactly 4 windows; last window p9=0x33.
//  2. Same frame, in_valid toggled 1-0-1 with random gaps.
//     -> same 4 windows, same values; out_valid never high in an idle cycle.
//  3. Two back-to-back frames, second frame pixel = 0x80|(row*16+col).
//     -> 8 windows total; second frame's first window p1=0x80, p9=0xA2.
//     -> no window mixes frames.
//  4. rst asserted after pixel 0x21, then a full frame is sent.
//     -> out_valid=0 during reset; next 4 windows match scenario 1.
//  5. in_sof reasserted at pixel 0x13 position (stream restarts at 0x00).
//     -> no window until restarted pixel 0x22; then 4 correct windows.
//  6. PREWITT_WIN_FLAGS_EN defined, scenario 1 stimulus.
//     -> win_eol on windows 2 and 4; win_eof only on window 4.
//  All scenarios: a scoreboard feeds p1..p9 to the vertical Prewitt kernel stage and
//  checks its output against a software model.

Source files
------------

// File: rtl/prewitt_pkg.sv
// Shared defaults, pixel type and counter-width helpers for the Prewitt window generator.
package prewitt_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IMG_W_DEF  = 64;
    localparam int unsigned IMG_H_DEF  = 64;

    typedef logic [DATA_W_DEF-1:0] pixel_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned COL_W = cnt_w(IMG_W_DEF);
    localparam int unsigned ROW_W = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/prewitt_line_buf.sv
// One image line of storage: synchronous write, combinational read, so a read and a write
// to the same address in one cycle return the old contents.
module prewitt_line_buf
    import prewitt_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W_DEF,
    parameter int unsigned WIDTH = DATA_W_DEF,
    parameter int unsigned AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/prewitt_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register, emitting only
// fully-interior windows. Define PREWITT_WIN_FLAGS_EN to add the win_eol/win_eof outputs.
module prewitt_window_gen
    import prewitt_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pix,
`ifdef PREWITT_WIN_FLAGS_EN
    output logic              win_eol,
    output logic              win_eof,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic [DATA_W-1:0] p9
);

    localparam int unsigned COL_BITS = cnt_w(IMG_W);
    localparam int unsigned ROW_BITS = cnt_w(IMG_H);

    logic [COL_BITS-1:0] col_q, col_d, col_eff;
    logic [ROW_BITS-1:0] row_q, row_d, row_eff;
    logic                col_last, row_last, win_ok;
    logic [DATA_W-1:0]   old_rd, mid_rd;

    // in_sof forces the current pixel to (0,0) regardless of where the counters were.
    always_comb begin
        col_eff  = in_sof ? '0 : col_q;
        row_eff  = in_sof ? '0 : row_q;
        col_last = (col_eff == COL_BITS'(IMG_W - 1));
        row_last = (row_eff == ROW_BITS'(IMG_H - 1));
        win_ok   = (row_eff >= ROW_BITS'(2)) && (col_eff >= COL_BITS'(2));
        col_d    = col_q;
        row_d    = row_q;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_eff + ROW_BITS'(1);
            end else begin
                col_d = col_eff + COL_BITS'(1);
                row_d = row_eff;
            end
        end
    end

    prewitt_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W),
        .AW    (COL_BITS)
    ) lb_old (
        .clk   (clk),
        .we    (in_valid && !rst),
        .addr  (col_eff),
        .wdata (mid_rd),
        .rdata (old_rd)
    );

    prewitt_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W),
        .AW    (COL_BITS)
    ) lb_mid (
        .clk   (clk),
        .we    (in_valid && !rst),
        .addr  (col_eff),
        .wdata (in_pix),
        .rdata (mid_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            out_valid <= 1'b0;
            p1 <= '0; p2 <= '0; p3 <= '0;
            p4 <= '0; p5 <= '0; p6 <= '0;
            p7 <= '0; p8 <= '0; p9 <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            out_valid <= in_valid && win_ok;
            if (in_valid) begin
                p1 <= p2; p2 <= p3; p3 <= old_rd;
                p4 <= p5; p5 <= p6; p6 <= mid_rd;
                p7 <= p8; p8 <= p9; p9 <= in_pix;
            end
        end
    end

`ifdef PREWITT_WIN_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            win_eol <= 1'b0;
            win_eof <= 1'b0;
        end else begin
            win_eol <= in_valid && win_ok && col_last;
            win_eof <= in_valid && win_ok && col_last && row_last;
        end
    end
`endif

endmodule

// File: tb/tb_prewitt_window_gen.sv
// Scoreboard bench for prewitt_window_gen at 4x4: expected windows are built from a model image
// when each pixel is driven and compared when out_valid is seen.
module tb_prewitt_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct packed {
        logic [71:0] win;
        logic        eol;
        logic        eof;
    } win_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pix = '0;
    logic       out_valid;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       eol_s, eof_s;

    int total = 0;
    int bad = 0;
    int win_cnt = 0;

    win_t exp_q[$];
    win_t log_q[$];

    logic [7:0] img [H][W];
    int m_row = 0;
    int m_col = 0;

    prewitt_window_gen #(
        .DATA_W (8),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
`ifdef PREWITT_WIN_FLAGS_EN
        .win_eol   (eol_s),
        .win_eof   (eof_s),
`endif
        .out_valid (out_valid),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p4        (p4),
        .p5        (p5),
        .p6        (p6),
        .p7        (p7),
        .p8        (p8),
        .p9        (p9)
    );

`ifndef PREWITT_WIN_FLAGS_EN
    assign eol_s = 1'b0;
    assign eof_s = 1'b0;
`endif

    always #5 clk = ~clk;

    // Vertical Prewitt kernel: right column minus left column.
    function automatic int vert(input logic [71:0] w);
        int r, l;
        r = int'(w[55:48]) + int'(w[31:24]) + int'(w[7:0]);
        l = int'(w[71:64]) + int'(w[47:40]) + int'(w[23:16]);
        return r - l;
    endfunction

    task automatic model_accept(input logic sof, input logic [7:0] pix);
        win_t e;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = pix;
        if (m_row >= 2 && m_col >= 2) begin
            e.win = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                     img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col],
                     img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]};
            e.eol = (m_col == W - 1);
            e.eof = (m_col == W - 1) && (m_row == H - 1);
            exp_q.push_back(e);
        end
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic send(input logic sof, input logic [7:0] pix);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pix   = pix;
        model_accept(sof, pix);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input logic sof_first, input logic gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(sof_first && r == 0 && c == 0, base | 8'(r * 16 + c));
                if (gaps) idle(int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic start_scenario();
        win_cnt = 0;
        log_q.delete();
    endtask

    task automatic check_drained(input string name, input int want);
        total++;
        if (win_cnt !== want) begin
            bad++;
            $display("FAIL %s window_count got=%0d want=%0d", name, win_cnt, want);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL %s pending_windows got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard: compare every produced window, its kernel output and flags.
    always @(negedge clk) begin
        win_t g, e;
        if (out_valid === 1'b1) begin
            g.win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
            g.eol = eol_s;
            g.eof = eof_s;
            win_cnt++;
            log_q.push_back(g);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_window got=%h want=none", g.win);
            end else begin
                e = exp_q.pop_front();
                if (g.win !== e.win) begin
                    bad++;
                    $display("FAIL window got=%h want=%h", g.win, e.win);
                end
                total++;
                if (vert(g.win) != vert(e.win)) begin
                    bad++;
                    $display("FAIL prewitt_vert got=%0d want=%0d", vert(g.win), vert(e.win));
                end
`ifdef PREWITT_WIN_FLAGS_EN
                total++;
                if ({g.eol, g.eof} !== {e.eol, e.eof}) begin
                    bad++;
                    $display("FAIL flags got=%b%b want=%b%b", g.eol, g.eof, e.eol, e.eof);
                end
`endif
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if ({p1, p2, p3, p4, p5, p6, p7, p8, p9} !== 72'h0) begin
            bad++;
            $display("FAIL reset_window got=%h want=0", {p1, p2, p3, p4, p5, p6, p7, p8, p9});
        end
        total++;
        if ({eol_s, eof_s} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags got=%b%b want=00", eol_s, eof_s);
        end
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic test_single_frame();
        logic [71:0] first_want;
        first_want = 72'h00_01_02_10_11_12_20_21_22;
        start_scenario();
        send_frame(8'h00, 1'b1, 1'b0);
        idle(3);
        check_drained("single_frame", 4);
        if (log_q.size() == 4) begin
            total++;
            if (log_q[0].win !== first_want) begin
                bad++;
                $display("FAIL first_window got=%h want=%h", log_q[0].win, first_want);
            end
            total++;
            if (log_q[3].win[7:0] !== 8'h33) begin
                bad++;
                $display("FAIL last_p9 got=%h want=33", log_q[3].win[7:0]);
            end
`ifdef PREWITT_WIN_FLAGS_EN
            total++;
            if ({log_q[0].eol, log_q[1].eol, log_q[2].eol, log_q[3].eol,
                 log_q[0].eof, log_q[1].eof, log_q[2].eof, log_q[3].eof} !== 8'b0101_0001) begin
                bad++;
                $display("FAIL flag_pattern got=%b%b%b%b_%b%b%b%b want=0101_0001",
                         log_q[0].eol, log_q[1].eol, log_q[2].eol, log_q[3].eol,
                         log_q[0].eof, log_q[1].eof, log_q[2].eof, log_q[3].eof);
            end
`endif
        end
    endtask

    task automatic test_gaps();
        start_scenario();
        send_frame(8'h00, 1'b1, 1'b1);
        idle(3);
        check_drained("gaps", 4);
    endtask

    task automatic test_back_to_back();
        start_scenario();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0);
        idle(3);
        check_drained("back_to_back", 8);
        if (log_q.size() == 8) begin
            total++;
            if ({log_q[4].win[71:64], log_q[4].win[7:0]} !== 16'h80_a2) begin
                bad++;
                $display("FAIL frame2_first got=%h_%h want=80_a2",
                         log_q[4].win[71:64], log_q[4].win[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        start_scenario();
        for (int i = 0; i < 10; i++) begin
            send(i == 0, 8'((i / W) * 16 + (i % W)));
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_out_valid got=%b want=0", out_valid);
            end
        end
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
        exp_q.delete();
        send_frame(8'h00, 1'b0, 1'b0);
        idle(3);
        check_drained("reset_mid_frame", 4);
    endtask

    task automatic test_sof_restart();
        start_scenario();
        for (int i = 0; i < 7; i++) begin
            send(i == 0, 8'((i / W) * 16 + (i % W)));
        end
        send_frame(8'h00, 1'b1, 1'b0);
        idle(3);
        check_drained("sof_restart", 4);
        if (log_q.size() == 4) begin
            total++;
            if (log_q[0].win[7:0] !== 8'h22) begin
                bad++;
                $display("FAIL restart_first_p9 got=%h want=22", log_q[0].win[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        test_sof_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
